irq_gateway: RTL
================

IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 SHALL have parameter NSRC, default 8, giving the number of external interrupt sources (1..15); source i maps to ID i+1, and ID 0 means "none".
REQ-002 SHALL have port clk, input, 1 bit: the single core clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port src_irq, input, NSRC bits: raw interrupt request lines, synchronous to clk.
REQ-005 SHALL have ports cfg_we (input, 1 bit), cfg_addr (input, 2 bits), cfg_wdata (input, NSRC bits) and cfg_rdata (output, NSRC bits, combinational read of the addressed register); together these form the configuration port.
REQ-006 SHALL have ports claim_req (input, 1 bit), claim_vld (output, 1 bit) and claim_id (output, 4 bits): the core's claim handshake.
REQ-007 SHALL have ports complete_vld (input, 1 bit) and complete_id (input, 4 bits): end-of-service notification from the core.
REQ-008 SHALL have port external_interrupt, output, 1 bit: drives the core's external_interrupt input.
REQ-009 SHALL have port core_wfi (input, 1 bit) from the core, and port wakeup (output, 1 bit), registered, that releases the core from WFI.
REQ-010 SHALL have port cpl_err, output, 1 bit: a one-cycle pulse on an illegal completion.

Function
REQ-011 SHALL implement these registers: addr0 ENABLE (R/W); addr1 EDGE (R/W, 1 = rising-edge source, 0 = level source); addr2 PENDING (read; writing 1 clears pending for edge sources only); addr3 STATUS (read, {zero-extend, in-service ID}).
REQ-012 SHALL detect a rising edge on src_irq[i] as src_irq[i]=1 with the previous-cycle sample=0; the edge sets pending[i] on the next clock.
REQ-013 SHALL hold pending[i] equal to src_irq[i] (registered) for a level source, unless source i is in service.
REQ-014 SHALL block the pending bit of the in-service source; an edge on that source during service SHALL set a one-deep replay bit, and the replay bit SHALL set pending at completion.
REQ-015 SHALL run a controller FSM with states IDLE, ASSERT and SERVICE.
REQ-016 IDLE SHALL move to ASSERT on the cycle after any bit of (pending & ENABLE) is set.
REQ-017 SHALL drive external_interrupt high only while in ASSERT.
REQ-018 In ASSERT, claim_req SHALL, in the same cycle, drive claim_vld=1 and claim_id = lowest-index pending enabled source + 1; the next clock SHALL clear that pending bit, record the in-service ID and enter SERVICE.
REQ-019 In ASSERT, if (pending & ENABLE) becomes 0 (for example ENABLE is cleared), the FSM SHALL return to IDLE; a claim_req in that same cycle SHALL return claim_vld=1, claim_id=0.
REQ-020 In IDLE or SERVICE, claim_req SHALL return claim_vld=1, claim_id=0 and cause no state change.
REQ-021 In SERVICE, complete_vld with complete_id equal to the in-service ID SHALL return the FSM to IDLE and clear the in-service ID to 0.
REQ-022 complete_vld with any other complete_id, or in any state other than SERVICE, SHALL pulse cpl_err for one cycle and be otherwise ignored.
REQ-023 The latency from a src_irq edge at cycle N (with the source enabled and the FSM in IDLE) SHALL be: pending set at N+1, external_interrupt high at N+2.
REQ-024 wakeup SHALL be registered as core_wfi & |(pending & ENABLE); it does not depend on the FSM state.
REQ-025 A config write and a pending set to the same bit in the same cycle SHALL resolve in favour of the set (the set wins over a write-1-clear).

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL clear: ENABLE=0, EDGE=0, PENDING=0, replay=0, the edge-sample register, and in-service ID=0; the FSM SHALL go to IDLE.
REQ-027 During and after reset, these outputs SHALL be 0: external_interrupt, claim_vld, claim_id, wakeup and cpl_err.
REQ-028 A reset mid-service SHALL abandon the in-service ID; any later completion SHALL raise cpl_err.

Verification
REQ-029 Edge path: ENABLE=0x01, EDGE=0x01; src_irq[0] 0->1 at cycle 10 -> pending[0] at cycle 11, external_interrupt at cycle 12; claim -> claim_id=1; complete id 1 -> IDLE.
REQ-030 Priority: sources 2 and 5 pending and enabled -> first claim_id=3; after completion, second claim_id=6.
REQ-031 Replay: source 0 in service; second edge arrives -> no external_interrupt; complete id 1 -> pending[0]=1 and external_interrupt after 2 cycles.
REQ-032 Level: EDGE=0, src_irq[3] held high through completion -> re-asserts; drop src_irq[3] before completion -> no re-assert.
REQ-033 Errors: complete id 4 while id 1 is in service -> one cpl_err pulse, still in SERVICE; claim in IDLE -> claim_id=0.
REQ-034 Reset/WFI: core_wfi=1 and pending enabled -> wakeup next cycle; rst asserted in SERVICE -> all outputs 0 and STATUS=0.

Source files
------------

// File: rtl/irq_gateway.sv
// Interrupt gateway: edge/level capture, pending/enable registers,
// and the claim/complete handshake with the core.
module irq_gateway #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [NSRC-1:0] cfg_wdata,
  output logic [NSRC-1:0] cfg_rdata,
  input  logic            claim_req,
  output logic            claim_vld,
  output logic [3:0]      claim_id,
  input  logic            complete_vld,
  input  logic [3:0]      complete_id,
  output logic            external_interrupt,
  input  logic            core_wfi,
  output logic            wakeup,
  output logic            cpl_err
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_t;

  state_t state_q, state_d;

  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] src_q;
  logic            replay_q, replay_d;
  logic [3:0]      isid_q, isid_d;
  logic            wake_q;

  logic [NSRC-1:0] act;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] svc_mask;
  logic [NSRC-1:0] pick;
  logic [3:0]      pick_id;
  logic            claim_fire;
  logic            cpl_ok;

  assign act  = pend_q & enable_q;
  assign rise = src_irq & ~src_q;
  assign w1c  = (cfg_we && cfg_addr == 2'd2)
              ? (cfg_wdata & edge_q) : '0;

  // Scan high to low so the lowest index wins.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        pick_id = 4'(i + 1);
      end
    end
  end

  always_comb begin
    svc_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      svc_mask[i] = (isid_q == 4'(i + 1));
    end
  end

  always_comb begin
    state_d    = state_q;
    isid_d     = isid_q;
    claim_fire = 1'b0;
    cpl_ok     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|act) state_d = ASSERT;
      end
      ASSERT: begin
        if (!(|act)) begin
          state_d = IDLE;
        end else if (claim_req) begin
          claim_fire = 1'b1;
          state_d    = SERVICE;
          isid_d     = pick_id;
        end
      end
      SERVICE: begin
        if (complete_vld && complete_id == isid_q) begin
          cpl_ok  = 1'b1;
          state_d = IDLE;
          isid_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The in-service bit stays blocked; edges meanwhile go to replay.
  always_comb begin
    pend_d   = pend_q;
    replay_d = cpl_ok ? 1'b0 : replay_q;
    for (int i = 0; i < NSRC; i++) begin
      if (edge_q[i]) begin
        pend_d[i] = (pend_q[i] & ~w1c[i]) | rise[i];
      end else begin
        pend_d[i] = src_irq[i];
      end
      if (svc_mask[i]) begin
        if (cpl_ok) begin
          pend_d[i] = pend_d[i] | replay_q;
        end else begin
          pend_d[i] = 1'b0;
          if (edge_q[i] && rise[i]) replay_d = 1'b1;
        end
      end
      if (claim_fire && pick[i]) begin
        pend_d[i] = 1'b0;
        replay_d  = edge_q[i] & rise[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      src_q    <= '0;
      replay_q <= 1'b0;
      isid_q   <= '0;
      wake_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      src_q    <= src_irq;
      replay_q <= replay_d;
      isid_q   <= isid_d;
      wake_q   <= core_wfi & (|act);
      if (cfg_we) begin
        unique case (1'b1)
          (cfg_addr == 2'd0): enable_q <= cfg_wdata;
          (cfg_addr == 2'd1): edge_q   <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = enable_q;
      2'd1:    cfg_rdata = edge_q;
      2'd2:    cfg_rdata = pend_q;
      default: cfg_rdata = NSRC'(isid_q);
    endcase
  end

  assign external_interrupt = ~rst & (state_q == ASSERT);
  assign claim_vld          = ~rst & claim_req;
  assign claim_id           = (~rst & claim_fire) ? pick_id : 4'd0;
  assign cpl_err            = ~rst & complete_vld & ~cpl_ok;
  assign wakeup             = ~rst & wake_q;

endmodule
